cam_entry_alloc: RTL and testbench
==================================

// Module: cam_entry_alloc
// PURPOSE
//  Allocation and occupancy tracker for the exact-match CAM write path.
//  Picks the lowest free entry for each insert and returns it to the requester.
//  Drives the entry-select decoder through wr_addr_o (decoder inp_i) and
//  wr_en_o (decoder enable). Invalidates every entry by sweeping after reset and on flush.
// PARAMETERS
//  SIZE     5           entry index width; ENTRIES = 2**SIZE (32)
// PORTS
//  clk_i          in   1        clock, all state on rising edge
//  rst_ni         in   1        async active-low reset
//  alloc_valid_i  in   1        insert request
//  alloc_ready_o  out  1        can accept insert; comb = (state==RUN) & ~full_o & ~flush_i
//  free_valid_i   in   1        release entry free_addr_i
//  free_addr_i    in   SIZE     entry to release
//  flush_i        in   1        drop all entries and re-invalidate the CAM
//  wr_en_o        out  1        CAM entry write strobe (to decoder enable)
//  wr_addr_o      out  SIZE     CAM entry index (to decoder inp_i)
//  clr_o          out  1        1 = write is an invalidate sweep, 0 = insert
//  occupied_o     out  ENTRIES  occupancy bitmap, bit i = entry i in use
//  count_o        out  SIZE+1   number of occupied entries, 0..32
//  full_o         out  1        count_o == ENTRIES
//  empty_o        out  1        count_o == 0
//  dbl_free_o     out  1        1-cycle pulse: free of an unoccupied entry
// BEHAVIOUR
//  Reset: state INIT, sweep counter 0. Outputs: wr_en_o=0, wr_addr_o=0, clr_o=0, occupied_o=0,
//   count_o=0, empty_o=1, full_o=0, dbl_free_o=0, alloc_ready_o=0.
//  FSM states: INIT -> RUN; RUN -> FLUSH on flush_i; FLUSH -> RUN when the sweep is done.
//  INIT/FLUSH sweep:
//   - All outputs except alloc_ready_o are registered.
//   - Sweep edge k (k=0..31) registers wr_en_o=1, clr_o=1, wr_addr_o=k.
//   - The edge after k=31 registers wr_en_o=0, clr_o=0 and enters RUN.
//   - The sweep takes 32 strobe cycles. alloc_ready_o=0 throughout.
//   - free_valid_i and flush_i are ignored during a sweep.
//  Flush: flush_i in RUN clears occupied_o and count_o on the same edge and enters FLUSH.
//   The first sweep strobe (addr 0) is registered on that same edge.
//  RUN:
//   - Alloc transfer = alloc_valid_i & alloc_ready_o.
//   - Index = lowest i with occupied_o[i]==0, from pre-edge state.
//   - The next edge sets occupied_o[i] and registers wr_en_o=1, clr_o=0, wr_addr_o=i.
//   - Latency is 1 cycle. Back-to-back transfers are allowed, one per cycle.
//   - Without a transfer, wr_en_o=0 and wr_addr_o holds its last value.
//  Free: free_valid_i with occupied_o[free_addr_i]=1 clears that bit at the next edge.
//   If the bit is 0, state is unchanged and dbl_free_o pulses on the next edge.
//  Simultaneous alloc + free:
//   - Both take effect and count_o is unchanged.
//   - The freed entry is not eligible for this alloc; it is reusable from the next cycle.
//   - When full, alloc_ready_o=0 even if a free is pending the same cycle.
//  Flush + alloc in the same cycle: the alloc is not accepted (ready low). Flush + free: flush wins.
//  Count arithmetic: count_o is SIZE+1 bits and never wraps. It stays consistent with the bitmap:
//   count_o == $countones(occupied_o) is an assertion.
//  Reset mid-sweep or mid-run: async return to the reset values. The sweep restarts at addr 0.
// TESTING
//  1. Release reset -> wr_en_o=1, clr_o=1 for 32 cycles with addr 0..31, then alloc_ready_o=1, empty_o=1.
//  2. 32 back-to-back allocs -> wr_addr_o 0,1,..,31 on consecutive cycles.
//     Then full_o=1, alloc_ready_o=0, count_o=32.
//  3. Full table, free 7, then alloc -> wr_addr_o=7. Free 3 and 9, then alloc -> 3, then alloc -> 9.
//  4. Entries 0..4 occupied; same cycle alloc + free 0 -> alloc gets 5, count_o stays 5.
//     The next alloc gets 0.
//  5. Free 12 while unoccupied -> dbl_free_o pulses 1 cycle; occupied_o and count_o unchanged.
//  6. flush_i with 10 entries held, alloc_valid_i=1 in the same cycle -> alloc not taken.
//     count_o=0 next cycle, 32-cycle clr sweep, then RUN.
//     Assert rst_ni low mid-sweep -> the sweep restarts at 0.

Source files
------------

// File: rtl/cam_entry_alloc_if.sv
// rtl/cam_entry_alloc_if.sv - request/write-path signal bundle for the CAM entry allocator
interface cam_entry_alloc_if #(
   parameter int SIZE = 5
);
   localparam int ENTRIES = 2 ** SIZE;

   logic               alloc_valid_i;
   logic               alloc_ready_o;
   logic               free_valid_i;
   logic [SIZE-1:0]    free_addr_i;
   logic               flush_i;
   logic               wr_en_o;
   logic [SIZE-1:0]    wr_addr_o;
   logic               clr_o;
   logic [ENTRIES-1:0] occupied_o;
   logic [SIZE:0]      count_o;
   logic               full_o;
   logic               empty_o;
   logic               dbl_free_o;

   // requester side: issues inserts, frees and flushes
   modport master (
      output alloc_valid_i, free_valid_i, free_addr_i, flush_i,
      input  alloc_ready_o, wr_en_o, wr_addr_o, clr_o, occupied_o, count_o,
             full_o, empty_o, dbl_free_o
   );

   // allocator side
   modport slave (
      input  alloc_valid_i, free_valid_i, free_addr_i, flush_i,
      output alloc_ready_o, wr_en_o, wr_addr_o, clr_o, occupied_o, count_o,
             full_o, empty_o, dbl_free_o
   );
endinterface

// File: rtl/cam_entry_alloc.sv
// rtl/cam_entry_alloc.sv - lowest-free entry allocator and occupancy tracker for the CAM write path
module cam_entry_alloc #(
   parameter int SIZE = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   cam_entry_alloc_if.slave  bus
);
   localparam int ENTRIES = 2 ** SIZE;
   localparam logic [SIZE:0] ENTRIES_W = (SIZE+1)'(ENTRIES);

   typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [SIZE:0]      sweep_q;
   logic               sweep_done;
   logic [ENTRIES-1:0] occ_q, occ_d;
   logic [SIZE:0]      cnt_q, cnt_d;
   logic               full_q, empty_q, dbl_q;
   logic               wr_en_q, clr_q;
   logic [SIZE-1:0]    addr_q;
   logic [SIZE-1:0]    free_idx;
   logic               alloc_ready, alloc_fire, free_req, free_hit, free_miss;

   // sweep counter runs one past the last entry so the hand-over edge is distinct
   assign sweep_done  = (sweep_q == ENTRIES_W);
   assign alloc_ready = (state_q == RUN) & ~full_q & ~bus.flush_i;
   assign alloc_fire  = bus.alloc_valid_i & alloc_ready;
   // frees only count in RUN without a flush; flush drops everything anyway
   assign free_req    = (state_q == RUN) & ~bus.flush_i & bus.free_valid_i;
   assign free_hit    = free_req &  occ_q[bus.free_addr_i];
   assign free_miss   = free_req & ~occ_q[bus.free_addr_i];

   // lowest clear bit of the pre-edge bitmap; a same-cycle free is not visible here
   always_comb begin
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!occ_q[i]) free_idx = SIZE'(i);
      end
   end

   // next bitmap and count; the alloc bit is clear and the freed bit is set, so they never collide
   always_comb begin
      occ_d = occ_q;
      if (alloc_fire) occ_d[free_idx] = 1'b1;
      if (free_hit)   occ_d[bus.free_addr_i] = 1'b0;
      cnt_d = cnt_q + (SIZE+1)'(alloc_fire) - (SIZE+1)'(free_hit);
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= INIT;
      else         state_q <= state_d;
   end

   // next-state: sweep after reset and flush, then serve inserts
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT, FLUSH: if (sweep_done) state_d = RUN;
         RUN:         if (bus.flush_i) state_d = FLUSH;
         default:     state_d = INIT;
      endcase
   end

   // registered write strobe, bitmap, count and status flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sweep_q <= '0;
         occ_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         dbl_q   <= 1'b0;
         wr_en_q <= 1'b0;
         clr_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         dbl_q <= 1'b0;
         case (state_q)
            INIT, FLUSH: begin
               if (sweep_done) begin
                  wr_en_q <= 1'b0;
                  clr_q   <= 1'b0;
                  sweep_q <= '0;
               end else begin
                  wr_en_q <= 1'b1;
                  clr_q   <= 1'b1;
                  addr_q  <= sweep_q[SIZE-1:0];
                  sweep_q <= sweep_q + 1'b1;
               end
            end
            RUN: begin
               if (bus.flush_i) begin
                  // flush edge doubles as sweep strobe 0
                  occ_q   <= '0;
                  cnt_q   <= '0;
                  full_q  <= 1'b0;
                  empty_q <= 1'b1;
                  wr_en_q <= 1'b1;
                  clr_q   <= 1'b1;
                  addr_q  <= '0;
                  sweep_q <= (SIZE+1)'(1);
               end else begin
                  occ_q   <= occ_d;
                  cnt_q   <= cnt_d;
                  full_q  <= (cnt_d == ENTRIES_W);
                  empty_q <= (cnt_d == '0);
                  dbl_q   <= free_miss;
                  wr_en_q <= alloc_fire;
                  clr_q   <= 1'b0;
                  if (alloc_fire) addr_q <= free_idx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alloc_ready_o = alloc_ready;
   assign bus.wr_en_o       = wr_en_q;
   assign bus.wr_addr_o     = addr_q;
   assign bus.clr_o         = clr_q;
   assign bus.occupied_o    = occ_q;
   assign bus.count_o       = cnt_q;
   assign bus.full_o        = full_q;
   assign bus.empty_o       = empty_q;
   assign bus.dbl_free_o    = dbl_q;

   // count must always equal the population of the bitmap
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q == (SIZE+1)'($countones(occ_q)));
endmodule

// File: tb/tb_cam_entry_alloc.sv
// tb/tb_cam_entry_alloc.sv - scoreboard bench for cam_entry_alloc
module tb_cam_entry_alloc;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cam_entry_alloc_if #(.SIZE(5)) bus ();
   cam_entry_alloc #(.SIZE(5)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [5:0]  exp_q[$];
   logic [31:0] m_occ;
   int          m_cnt;
   bit          m_run;
   int          m_rem;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [31:0] m);
      for (int i = 0; i < 32; i++) if (!m[i]) return i;
      return 0;
   endfunction

   task automatic push_sweep();
      for (int i = 0; i < 32; i++) exp_q.push_back({1'b1, 5'(i)});
   endtask

   task automatic model_reset();
      m_occ = '0;
      m_cnt = 0;
      m_run = 0;
      m_rem = 33;
      exp_q.delete();
      push_sweep();
   endtask

   task automatic step(input bit av, input bit fv, input logic [4:0] fa, input bit fl);
      bit          rdy, acc, exp_wr, exp_dbl;
      logic [31:0] pre;
      int          idx;
      logic [5:0]  e;
      bus.alloc_valid_i = av;
      bus.free_valid_i  = fv;
      bus.free_addr_i   = fa;
      bus.flush_i       = fl;
      #1;
      rdy = m_run && (m_cnt != 32) && !fl;
      chk("alloc_ready", bus.alloc_ready_o, rdy);
      pre     = m_occ;
      acc     = av && rdy;
      exp_wr  = 0;
      exp_dbl = 0;
      if (!m_run) begin
         exp_wr = (m_rem > 1);
         m_rem--;
         if (m_rem == 0) m_run = 1;
      end else if (fl) begin
         m_occ  = '0;
         m_cnt  = 0;
         m_run  = 0;
         m_rem  = 32;
         exp_wr = 1;
         push_sweep();
      end else begin
         if (acc) begin
            idx = lowest(pre);
            m_occ[idx] = 1'b1;
            m_cnt++;
            exp_q.push_back({1'b0, 5'(idx)});
            exp_wr = 1;
         end
         if (fv) begin
            if (pre[fa]) begin
               m_occ[fa] = 1'b0;
               m_cnt--;
            end else exp_dbl = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("wr_en", bus.wr_en_o, exp_wr);
      if (bus.wr_en_o) begin
         if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_clr_addr", {bus.clr_o, bus.wr_addr_o}, e);
         end
      end
      chk("occupied", bus.occupied_o, m_occ);
      chk("count", bus.count_o, m_cnt);
      chk("full", bus.full_o, m_cnt == 32);
      chk("empty", bus.empty_o, m_cnt == 0);
      chk("dbl_free", bus.dbl_free_o, exp_dbl);
   endtask

   task automatic chk_reset_vals();
      chk("rst_wr_en", bus.wr_en_o, 0);
      chk("rst_wr_addr", bus.wr_addr_o, 0);
      chk("rst_clr", bus.clr_o, 0);
      chk("rst_occupied", bus.occupied_o, 0);
      chk("rst_count", bus.count_o, 0);
      chk("rst_empty", bus.empty_o, 1);
      chk("rst_full", bus.full_o, 0);
      chk("rst_dbl_free", bus.dbl_free_o, 0);
      chk("rst_ready", bus.alloc_ready_o, 0);
   endtask

   initial begin
      bus.alloc_valid_i = 1'b0;
      bus.free_valid_i  = 1'b0;
      bus.free_addr_i   = '0;
      bus.flush_i       = 1'b0;
      #12;
      chk_reset_vals();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // init sweep
      repeat (33) step(0, 0, 0, 0);
      // fill the table back to back
      repeat (32) step(1, 0, 0, 0);
      // full: alloc refused even with a free pending
      step(1, 1, 7, 0);
      step(1, 0, 0, 0);
      step(0, 1, 3, 0);
      step(0, 1, 9, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      // flush, sweep, then alloc + free in the same cycle
      step(0, 0, 0, 1);
      repeat (32) step(0, 0, 0, 0);
      repeat (5) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      // double free
      step(0, 1, 12, 0);
      // hold ten entries, then flush with a competing alloc
      repeat (4) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      repeat (10) step(0, 0, 0, 0);
      // reset in the middle of the sweep
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      model_reset();
      rst_n = 1'b1;
      repeat (33) step(0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), ($urandom_range(0, 59) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
